clock_display_scan: RTL and testbench

- Downstream stage of the time-of-day counter core.
- Consumes its hour, minute and second digit outputs plus the AM/PM flags, and drives a 6-digit multiplexed common-cathode 7-segment display.
- Per frame: snapshots the digits, scans one digit per slot, decodes BCD to segments, blanks the hour leading zero in 12-hour mode, shows PM on a decimal point, and blinks a selected field while time is being set.

---
 rtl/clock_display_scan.sv | 241 ++++++++++++++++++++++++
 tb/tb_clock_display_scan.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/clock_display_scan.sv
// -----------------------------------------------------------------------------
// clock_display_scan
//
// Drives a 6-digit multiplexed common-cathode 7-segment display from the
// time-of-day counter's BCD digit outputs.
//
// Operation:
//   - Digits are snapshotted once per frame, at the first edge of slot 0, so
//     the whole frame shows one consistent time even if the inputs change
//     while the frame is being scanned.
//   - One digit is lit per slot of SCAN_DIV clocks. Slots run
//     idx 0..5 = s0, s1, m0, m1, h0, h1, and idx 0 is the rightmost digit.
//   - In 12 h mode a zero hours-tens digit is blanked, and PM is shown on the
//     decimal point of the rightmost digit.
//   - While blink_phase is 1, the field picked by blink_sel is blanked.
//     blink_phase toggles every BLINK_DIV frames.
//
// Parameters:
//   SCAN_DIV   clk cycles per digit slot (>= 2)
//   BLINK_DIV  frames per blink half-period (>= 1)
//
// Ports:
//   clk        system clock
//   r          synchronous active-high reset
//   h1..s0     hour/minute/second BCD digits (narrow ones are zero-extended)
//   am, pm     AM/PM flags; may be X in 24 h mode. Only pm affects the display
//   hour_24    1 = 24 h display, 0 = 12 h display
//   blink_sel  field to blink: 0 none, 1 hours, 2 minutes, 3 seconds
//   seg        {g,f,e,d,c,b,a}, active high, registered
//   dp         decimal point, active high, registered
//   an         one-hot digit enable (bit0 = rightmost), registered
//   frame_done one-cycle pulse on the edge where idx wraps 5 -> 0
// -----------------------------------------------------------------------------
module clock_display_scan #(
    parameter int SCAN_DIV  = 1000,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       r,
    input  logic [2:0] h1,
    input  logic [4:0] h0,
    input  logic [3:0] m1,
    input  logic [4:0] m0,
    input  logic [3:0] s1,
    input  logic [4:0] s0,
    input  logic       am,
    input  logic       pm,
    input  logic       hour_24,
    input  logic [1:0] blink_sel,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_done
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // Scan position and blink state
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [BW-1:0] frame_cnt;
    logic          blink_phase;

    // Per-frame snapshot of the displayed time
    logic [2:0] sn_h1;
    logic [4:0] sn_h0;
    logic [3:0] sn_m1;
    logic [4:0] sn_m0;
    logic [3:0] sn_s1;
    logic [4:0] sn_s0;
    logic       sn_pm;
    logic       sn_h24;

    // am carries no information the display needs beyond pm.
    logic unused_am;
    assign unused_am = am;

    logic slot_end;
    logic frame_end;
    logic load;

    assign slot_end  = (cnt == CW'(SCAN_DIV - 1));
    assign frame_end = slot_end && (idx == 3'd5);
    assign load      = (cnt == '0) && (idx == 3'd0);

    // X-safe pm. An X condition takes the default branch, so an unknown pm
    // reads as 0 and never reaches dp.
    logic pm_bit;
    always_comb begin
        pm_bit = 1'b0;
        if (pm == 1'b1) begin
            pm_bit = 1'b1;
        end
    end

    // On the load edge the snapshot is only being written, so the live
    // inputs (identical to what is being loaded) feed the slot-0 output.
    logic [2:0] cur_h1;
    logic [4:0] cur_h0;
    logic [3:0] cur_m1;
    logic [4:0] cur_m0;
    logic [3:0] cur_s1;
    logic [4:0] cur_s0;
    logic       cur_pm;
    logic       cur_h24;

    always_comb begin
        cur_h1  = load ? h1      : sn_h1;
        cur_h0  = load ? h0      : sn_h0;
        cur_m1  = load ? m1      : sn_m1;
        cur_m0  = load ? m0      : sn_m0;
        cur_s1  = load ? s1      : sn_s1;
        cur_s0  = load ? s0      : sn_s0;
        cur_pm  = load ? pm_bit  : sn_pm;
        cur_h24 = load ? hour_24 : sn_h24;
    end

    // Digit select, zero-extended to 5 bits
    logic [4:0] digit;
    always_comb begin
        digit = 5'd0;
        case (idx)
            3'd0:    digit = cur_s0;
            3'd1:    digit = {1'b0, cur_s1};
            3'd2:    digit = cur_m0;
            3'd3:    digit = {1'b0, cur_m1};
            3'd4:    digit = cur_h0;
            3'd5:    digit = {2'b00, cur_h1};
            default: digit = 5'd0;
        endcase
    end

    // BCD to segments; any non-decimal value shows a dash.
    logic [6:0] seg_dec;
    always_comb begin
        seg_dec = 7'h40;
        case (digit)
            5'd0:    seg_dec = 7'h3F;
            5'd1:    seg_dec = 7'h06;
            5'd2:    seg_dec = 7'h5B;
            5'd3:    seg_dec = 7'h4F;
            5'd4:    seg_dec = 7'h66;
            5'd5:    seg_dec = 7'h6D;
            5'd6:    seg_dec = 7'h7D;
            5'd7:    seg_dec = 7'h07;
            5'd8:    seg_dec = 7'h7F;
            5'd9:    seg_dec = 7'h6F;
            default: seg_dec = 7'h40;
        endcase
    end

    // The blink field is read live, so a new blink_sel applies to the next slot.
    logic blink_hit;
    always_comb begin
        blink_hit = 1'b0;
        case (blink_sel)
            2'd1:    blink_hit = (idx == 3'd4) || (idx == 3'd5);
            2'd2:    blink_hit = (idx == 3'd2) || (idx == 3'd3);
            2'd3:    blink_hit = (idx == 3'd0) || (idx == 3'd1);
            default: blink_hit = 1'b0;
        endcase
    end

    logic       blank_blink;
    logic       blank_lz;
    logic [6:0] seg_next;
    logic       dp_next;
    logic [5:0] an_next;

    always_comb begin
        blank_blink = blink_phase && blink_hit;
        blank_lz    = (idx == 3'd5) && !cur_h24 && (cur_h1 == 3'd0);
        seg_next    = (blank_blink || blank_lz) ? 7'h00 : seg_dec;
        dp_next     = (idx == 3'd0) && !cur_h24 && cur_pm && !blank_blink;
        an_next     = 6'b000000;
        case (idx)
            3'd0:    an_next = 6'b000001;
            3'd1:    an_next = 6'b000010;
            3'd2:    an_next = 6'b000100;
            3'd3:    an_next = 6'b001000;
            3'd4:    an_next = 6'b010000;
            3'd5:    an_next = 6'b100000;
            default: an_next = 6'b000000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (r) begin
            cnt         <= '0;
            idx         <= 3'd0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            sn_h1       <= '0;
            sn_h0       <= '0;
            sn_m1       <= '0;
            sn_m0       <= '0;
            sn_s1       <= '0;
            sn_s0       <= '0;
            sn_pm       <= 1'b0;
            sn_h24      <= 1'b0;
            seg         <= 7'h00;
            dp          <= 1'b0;
            an          <= 6'b000000;
            frame_done  <= 1'b0;
        end else begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == 3'd5) ? 3'd0 : idx + 3'd1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            if (frame_end) begin
                if (frame_cnt == BW'(BLINK_DIV - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end

            if (load) begin
                sn_h1  <= h1;
                sn_h0  <= h0;
                sn_m1  <= m1;
                sn_m0  <= m0;
                sn_s1  <= s1;
                sn_s0  <= s0;
                sn_pm  <= pm_bit;
                sn_h24 <= hour_24;
            end

            seg        <= seg_next;
            dp         <= dp_next;
            an         <= an_next;
            frame_done <= frame_end;
        end
    end

endmodule

// File: tb/tb_clock_display_scan.sv
// -----------------------------------------------------------------------------
// tb_clock_display_scan
//
// Directed bench for clock_display_scan with SCAN_DIV=2 and BLINK_DIV=2.
// Each frame is 12 clocks long. Edge e (0..11) of a frame shows slot e/2,
// and frame_done is set on edge 11. Expected segment patterns per slot are
// written out by hand for each scenario.
// -----------------------------------------------------------------------------
module tb_clock_display_scan;

    logic       clk;
    logic       r;
    logic [2:0] h1;
    logic [4:0] h0;
    logic [3:0] m1;
    logic [4:0] m0;
    logic [3:0] s1;
    logic [4:0] s0;
    logic       am;
    logic       pm;
    logic       hour_24;
    logic [1:0] blink_sel;
    logic [6:0] seg;
    logic       dp;
    logic [5:0] an;
    logic       frame_done;

    int checks   = 0;
    int failures = 0;

    clock_display_scan #(
        .SCAN_DIV (2),
        .BLINK_DIV(2)
    ) dut (
        .clk       (clk),
        .r         (r),
        .h1        (h1),
        .h0        (h0),
        .m1        (m1),
        .m0        (m0),
        .s1        (s1),
        .s0        (s0),
        .am        (am),
        .pm        (pm),
        .hour_24   (hour_24),
        .blink_sel (blink_sel),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .frame_done(frame_done)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge, then sample away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"},  {2'b00, an},          8'h00);
        check({tag, "_seg"}, {1'b0, seg},          8'h00);
        check({tag, "_dp"},  {7'b0, dp},           8'h00);
        check({tag, "_fd"},  {7'b0, frame_done},   8'h00);
    endtask

    // Step through edges first..last of a frame and check each one against
    // the expected per-slot segments (es) and decimal points (ed).
    task automatic run_slots(input string name, input int first, input int last,
                             input logic [5:0][6:0] es, input logic [5:0] ed);
        for (int e = first; e <= last; e++) begin
            int i;
            step();
            i = e / 2;
            check($sformatf("%s_an_e%0d", name, e),  {2'b00, an},        8'(1 << i));
            check($sformatf("%s_seg_e%0d", name, e), {1'b0, seg},        {1'b0, es[i]});
            check($sformatf("%s_dp_e%0d", name, e),  {7'b0, dp},         {7'b0, ed[i]});
            check($sformatf("%s_fd_e%0d", name, e),  {7'b0, frame_done}, (e == 11) ? 8'h01 : 8'h00);
        end
    endtask

    task automatic run_frame(input string name, input logic [5:0][6:0] es, input logic [5:0] ed);
        run_slots(name, 0, 11, es, ed);
    endtask

    // Expected segments, listed idx5 (h1) down to idx0 (s0)
    logic [5:0][6:0] es_a;  // 12:34:56
    logic [5:0][6:0] es_b;  // 12 h, 09:34:56, leading zero blanked
    logic [5:0][6:0] es_d;  // 12:34:57
    logic [5:0][6:0] es_e;  // hour ones = 12 -> dash
    logic [5:0][6:0] es_f;  // 12:34:57 with minutes blanked

    initial begin
        es_a = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D};
        es_b = {7'h00, 7'h6F, 7'h4F, 7'h66, 7'h6D, 7'h7D};
        es_d = {7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h07};
        es_e = {7'h06, 7'h40, 7'h4F, 7'h66, 7'h6D, 7'h07};
        es_f = {7'h06, 7'h5B, 7'h00, 7'h00, 7'h6D, 7'h07};

        // Reset with 12:34:56 in 24 h mode
        r         = 1'b1;
        h1        = 3'd1;
        h0        = 5'd2;
        m1        = 4'd3;
        m0        = 5'd4;
        s1        = 4'd5;
        s0        = 5'd6;
        am        = 1'b0;
        pm        = 1'b0;
        hour_24   = 1'b1;
        blink_sel = 2'd0;
        repeat (3) step();
        check_reset_outputs("reset");
        r = 1'b0;

        // Plain scan, two frames
        run_frame("scan0", es_a, 6'b000000);
        run_frame("scan1", es_a, 6'b000000);

        // 12 h mode, 09 PM: blank leading zero, dp on idx0
        hour_24 = 1'b0;
        h1      = 3'd0;
        h0      = 5'd9;
        pm      = 1'b1;
        run_frame("pm12", es_b, 6'b000001);

        // 24 h mode with unknown AM/PM flags: dp stays low
        hour_24 = 1'b1;
        h1      = 3'd1;
        h0      = 5'd2;
        am      = 1'bx;
        pm      = 1'bx;
        run_frame("pmx", es_a, 6'b000000);

        // s0 changes during the idx3 slot: this frame keeps the snapshot
        am = 1'b0;
        pm = 1'b0;
        run_slots("tear", 0, 6, es_a, 6'b000000);
        s0 = 5'd7;
        run_slots("tear", 7, 11, es_a, 6'b000000);
        run_frame("tear_next", es_d, 6'b000000);

        // Non-decimal hours ones digit decodes to a dash
        h0 = 5'd12;
        run_frame("dash", es_e, 6'b000000);

        // Blink minutes starting from a fresh reset
        h0        = 5'd2;
        blink_sel = 2'd2;
        r         = 1'b1;
        step();
        check_reset_outputs("reset2");
        r = 1'b0;
        run_frame("blink_f0", es_d, 6'b000000);
        run_frame("blink_f1", es_d, 6'b000000);
        run_frame("blink_f2", es_f, 6'b000000);
        run_frame("blink_f3", es_f, 6'b000000);
        run_frame("blink_f4", es_d, 6'b000000);
        run_frame("blink_f5", es_d, 6'b000000);

        // The blink phase is now blanking. Reset during the idx3 slot aborts
        // the frame, and the scan restarts visible.
        run_slots("abort", 0, 6, es_f, 6'b000000);
        r = 1'b1;
        step();
        check_reset_outputs("reset_mid");
        r = 1'b0;
        run_frame("restart", es_d, 6'b000000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
